// File: rtl/cpu_pkg.sv
// Shared types and sizing for the 8-bit CPU datapath blocks.
// Holds the RAM address/data widths, the RAM controller state type and a write-qualify helper.
package cpu_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  // A bus store needs a write strobe, no front-panel ownership and no
  // simultaneous drive request (drive wins an illegal control word).
  function automatic logic bus_write_ok(input logic write_from_bus,
                                        input logic output_to_bus,
                                        input logic manual_mode);
    return write_from_bus && !output_to_bus && !manual_mode;
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Front-panel push-button conditioner: 2-flop synchronizer, history flop,
// and a single-cycle pulse on each synchronized rising edge.
module button_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulse = s2_q && !s3_q;

endmodule

// File: rtl/random_access_memory.sv
// 16 x 8 main memory for the 8-bit CPU: bus and front-panel write paths,
// combinational read, and a clear sequencer that zeroes the array after reset.
module random_access_memory #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_from_bus,
  input  logic              output_to_bus,
  input  logic              manual_mode,
  input  logic              manual_write,
  input  logic [DATA_W-1:0] manual_data_switches,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  import cpu_pkg::*;

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              manual_pulse;

  button_edge_detect u_manual_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (manual_write),
    .pulse   (manual_pulse)
  );

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    mem_we      = 1'b0;
    mem_waddr   = address;
    mem_wdata   = bus_in;
    unique case (state_q)
      CLEAR: begin
        // Edges seen during the clear are consumed here and never replayed.
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = '0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (manual_mode) begin
          mem_we    = manual_pulse;
          mem_wdata = manual_data_switches;
        end else begin
          mem_we    = bus_write_ok(write_from_bus, output_to_bus, manual_mode);
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    // The array must stay untouched while reset is held.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    busy      = (state_q == CLEAR);
    data_out  = mem_q[address];
    bus_drive = output_to_bus && !busy;
    bus_out   = bus_drive ? data_out : '0;
  end

endmodule

// File: doc/random_access_memory.md
# random_access_memory

16 × 8-bit main memory for the 8-bit CPU, sitting directly downstream of the memory address register. It consumes the 4-bit MAR address, writes the bus byte into the addressed location under control-word command, and drives the stored byte onto the bus when enabled. A manual-programming path writes the front-panel data switches on a debounced button press. A reset-time clear sequencer zeroes the whole array before the memory accepts traffic.

## Interface
- ADDR_W, 4, address width; depth = 2**ADDR_W
- DATA_W, 8, word width
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- address  in  ADDR_W  location select, driven by the MAR address output
- write_from_bus  in  1  control word: store bus_in at address
- output_to_bus  in  1  control word: drive the stored word on the bus
- manual_mode  in  1  1 = front-panel programming; bus writes ignored
- manual_write  in  1  raw push-button, asynchronous, active-high
- manual_data_switches  in  DATA_W  byte written by a manual press
- bus_in  in  DATA_W  current bus value
- bus_out  out  DATA_W  word driven to the bus mux; 0 when not driving
- bus_drive  out  1  bus-mux enable for this block
- data_out  out  DATA_W  mem[address], always valid, for the display LEDs
- busy  out  1  clear sequence in progress

## Operation
- States: CLEAR, RUN. busy = (state == CLEAR).
- rst=1: state←CLEAR, clear_ptr←0, all synchronizer and edge flops←0. The array is not written while rst is high.
- CLEAR, rst=0: mem[clear_ptr]←0 and clear_ptr←clear_ptr+1 each edge. At clear_ptr == depth−1 the edge moves state←RUN; there is no wrap back into CLEAR.
- RUN, bus write: when write_from_bus && !manual_mode && !output_to_bus, mem[address]←bus_in.
- RUN, manual write: when manual_pulse && manual_mode, mem[address]←manual_data_switches.
- Simultaneous write_from_bus and output_to_bus is an illegal control word. The drive takes priority and the write is suppressed.
- In CLEAR, all writes are ignored and bus_drive=0. A button edge detected during CLEAR is dropped, not queued.
- data_out = mem[address] (combinational read).
- bus_drive = output_to_bus && !busy.
- bus_out = bus_drive ? data_out : 0.
- rst asserted mid-operation: the clear restarts from address 0 on the first edge after rst falls. Contents written before the reset are zeroed.

## Timing
- Reset values: state=CLEAR, busy=1, bus_drive=0, bus_out=0. data_out shows the array content, which is undefined until cleared.
- Clear latency: busy falls after exactly depth (16) rising edges with rst=0. mem[i] is zero after edge i+1.
- Bus write: value captured at the edge. data_out reflects it immediately after that edge if address is unchanged.
- Read: zero-cycle latency from address/output_to_bus to bus_out.
- Manual path: 2-flop synchronizer (s1, s2) plus history flop s3; manual_pulse = s2 && !s3.
  - A button rising before edge k is captured in s1 at edge k.
  - The pulse is high during the cycle after edge k+1; the write commits at edge k+2.
  - Exactly one pulse per press, regardless of hold length.
- A manual_mode change takes effect on the same edge. A pulse arriving while manual_mode=0 writes nothing.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W=4, DATA_W=8, MEM_DEPTH
  - typedef ram_state_t {CLEAR, RUN}
  - typedefs addr_t and data_t
- Sub-module button_edge_detect holds the 2-flop synchronizer, history flop and single-cycle pulse. It is reusable for other front-panel buttons.
- The array is a plain logic array with synchronous write and asynchronous read, mapping to distributed RAM.

## Test plan
- Clear: rst high 3 cycles, then low → busy=1 for exactly 16 edges. All 16 data_out reads are 0x00 after busy falls.
- Bus write/read: address=4'hA, bus_in=8'h5C, write_from_bus 1 cycle, then output_to_bus → bus_drive=1, bus_out=0x5C. Address 4'hB still reads 0x00.
- Manual press: manual_mode=1, address=4'h3, switches=8'hE7, button held 10 cycles → mem[3]=0xE7 written exactly once, at the 2nd edge after capture.
- Manual-mode lockout: manual_mode=1, write_from_bus with bus_in=8'hFF at address 4'h3 → mem[3] unchanged.
- Illegal control word: write_from_bus and output_to_bus together, bus_in=8'h11, mem[2]=0x42 → bus_out=0x42 and mem[2] stays 0x42.
- Reset mid-run: fill addresses 0–15 with 0xAA, pulse rst 1 cycle → 16-cycle busy, and all locations read 0x00. A button press during busy produces no write.
